// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and the load/store path, with command latching and a per-access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  // Fetch requester
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_ack,
  output logic [DATA_W-1:0]     o_if_rdata,

  // Load/store requester
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [ADDR_W-1:0]     i_ls_addr,
  input  logic [DATA_W-1:0]     i_ls_wdata,
  input  logic [DATA_W/8-1:0]   i_ls_be,
  output logic                  o_ls_ack,
  output logic [DATA_W-1:0]     o_ls_rdata,

  // Status
  output logic                  o_bus_err,
  output logic                  o_stall,

  // Memory side
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_ready,
  input  logic [DATA_W-1:0]     i_mem_rdata,

  // Debug view of the FSM state
  output logic [1:0]            o_dbg_state
);

  // Handshakes: a requester raises req and holds it with a stable payload until
  // its ack pulse; the memory command is valid while mem_req is high and is
  // consumed on the edge where mem_ready is sampled high.

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_last_ls;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_if_ack;
  logic               r_ls_ack;
  logic               r_bus_err;
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_ls_rdata;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [BE_W-1:0]    r_mem_be;

  logic               w_if_elig;
  logic               w_ls_elig;
  logic               w_grant_if;
  logic               w_grant_ls;
  logic               w_busy;
  logic               w_busy_if;
  logic               w_busy_ls;
  logic               w_done;
  logic               w_tmo;

  // A requester whose ack is on the bus this cycle is still holding req from
  // the finished access, so it must not be granted again.
  assign w_if_elig = i_if_req & ~r_if_ack;
  assign w_ls_elig = i_ls_req & ~r_ls_ack;

  assign w_done = w_busy & i_mem_ready;
  assign w_tmo  = w_busy & ~i_mem_ready & (r_cnt == TMO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_ls) begin
          w_state_nxt = ST_BUSY_LS;
        end else if (w_grant_if) begin
          w_state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_LS: begin
        if (w_done || w_tmo) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    w_busy_if  = 1'b0;
    w_busy_ls  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a tie the requester that did not win last time is served.
        w_grant_ls = w_ls_elig & (~w_if_elig | ~r_last_ls);
        w_grant_if = w_if_elig & (~w_ls_elig |  r_last_ls);
      end
      ST_BUSY_IF: w_busy_if = 1'b1;
      ST_BUSY_LS: w_busy_ls = 1'b1;
      default: begin
        w_grant_if = 1'b0;
        w_grant_ls = 1'b0;
      end
    endcase
    w_busy    = w_busy_if | w_busy_ls;
    o_mem_req = w_busy;
  end

  // ---------------------------------------------------------------------------
  // Command latch, round-robin pointer and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_ls   <= 1'b0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      if (w_grant_ls) begin
        r_last_ls   <= 1'b1;
        r_cnt       <= '0;
        r_mem_we    <= i_ls_we;
        r_mem_addr  <= i_ls_addr;
        r_mem_wdata <= i_ls_wdata;
        r_mem_be    <= i_ls_be;
      end else if (w_grant_if) begin
        r_last_ls   <= 1'b0;
        r_cnt       <= '0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= i_if_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= '1;
      end else if (w_busy && !i_mem_ready && !w_tmo) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path: ack pulses, bus error and read data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_bus_err  <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_if_ack  <= w_busy_if & (w_done | w_tmo);
      r_ls_ack  <= w_busy_ls & (w_done | w_tmo);
      r_bus_err <= w_tmo;

      if (w_busy_if && w_done) begin
        r_if_rdata <= i_mem_rdata;
      end else if (w_busy_if && w_tmo) begin
        r_if_rdata <= '0;
      end

      // A completed store leaves the load data register untouched.
      if (w_busy_ls && w_done && !r_mem_we) begin
        r_ls_rdata <= i_mem_rdata;
      end else if (w_busy_ls && w_tmo) begin
        r_ls_rdata <= '0;
      end
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_ls_ack    = r_ls_ack;
  assign o_bus_err   = r_bus_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_dbg_state = r_state;

  assign o_stall = (i_if_req & ~r_if_ack) | (i_ls_req & ~r_ls_ack);

endmodule
